// File: rtl/uart_rfifo.sv
// rtl/uart_rfifo.sv - UART receive FIFO with per-entry error flags, overrun and error summary.
module uart_rfifo #(
    parameter int fifo_width     = 11,
    parameter int fifo_depth     = 16,
    parameter int fifo_pointer_w = 4,
    parameter int fifo_counter_w = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [fifo_width-1:0]     data_in,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    output logic [fifo_width-1:0]     data_out,
    output logic [fifo_counter_w-1:0] count,
    output logic                      overrun,
    output logic                      read_empty,
    output logic                      error_bit
);

    localparam logic [fifo_counter_w-1:0] full_count = fifo_counter_w'(fifo_depth);
    localparam logic [fifo_pointer_w-1:0] last_ptr   = fifo_pointer_w'(fifo_depth - 1);

    // Character bits live in plain storage; the 3 error bits are kept apart so they can be reset.
    logic [fifo_width-1:3]     char_mem [fifo_depth];
    logic [2:0]                err_mem  [fifo_depth];
    logic [fifo_pointer_w-1:0] wr_ptr;
    logic [fifo_pointer_w-1:0] rd_ptr;
    logic                      do_push;
    logic                      do_pop;
    logic                      overrun_set;

    function automatic logic [fifo_pointer_w-1:0] next_ptr(input logic [fifo_pointer_w-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    // A simultaneous pop frees the slot, so a push at full is still accepted.
    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && ((count != full_count) || do_pop);
        overrun_set = push && !do_pop && (count == full_count);
    end

    always_ff @(posedge clk) begin
        if (do_push && !fifo_reset)
            char_mem[wr_ptr] <= data_in[fifo_width-1:3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < fifo_depth; i++)
                err_mem[i] <= 3'b000;
        end else if (fifo_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < fifo_depth; i++)
                err_mem[i] <= 3'b000;
        end else begin
            if (do_push) begin
                err_mem[wr_ptr] <= data_in[2:0];
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (reset_status)
                overrun <= 1'b0;
            else if (overrun_set)
                overrun <= 1'b1;
        end
    end

    // Only entries between the read pointer and the stored count contribute to the summary.
    always_comb begin
        error_bit = 1'b0;
        for (int i = 0; i < fifo_depth; i++) begin
            int off;
            off = (i >= int'(rd_ptr)) ? i - int'(rd_ptr) : i + fifo_depth - int'(rd_ptr);
            if ((off < int'(count)) && (err_mem[i] != 3'b000))
                error_bit = 1'b1;
        end
    end

    assign data_out   = {char_mem[rd_ptr], err_mem[rd_ptr]};
    assign read_empty = (count == '0);

endmodule

// File: tb/tb_uart_rfifo.sv
// tb/tb_uart_rfifo.sv - directed self-checking bench for uart_rfifo.
module tb_uart_rfifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] data_in = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        fifo_reset = 1'b0;
    logic        reset_status = 1'b0;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        overrun;
    logic        read_empty;
    logic        error_bit;

    int n_checks = 0;
    int n_bad = 0;
    logic [10:0] model[$];

    uart_rfifo dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .push(push), .pop(pop),
        .fifo_reset(fifo_reset), .reset_status(reset_status), .data_out(data_out),
        .count(count), .overrun(overrun), .read_empty(read_empty), .error_bit(error_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the capturing edge.
    task automatic step(input logic p, input logic q, input logic fr, input logic rs,
                        input logic [10:0] d);
        @(negedge clk);
        push = p; pop = q; fifo_reset = fr; reset_status = rs; data_in = d;
        @(posedge clk);
        #1;
        push = 0; pop = 0; fifo_reset = 0; reset_status = 0;
    endtask

    initial begin
        #12;
        check("rst_count", count, 0);
        check("rst_empty", read_empty, 1);
        check("rst_err", error_bit, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        step(1, 0, 0, 0, 11'h208);
        check("p1_count", count, 1);
        check("p1_empty", read_empty, 0);
        check("p1_data", data_out, 11'h208);
        check("p1_err", error_bit, 0);
        step(0, 1, 0, 0, '0);
        check("p1_pop_empty", read_empty, 1);
        step(0, 1, 0, 0, '0);
        check("pop_empty_count", count, 0);

        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 0, 11'((8'h30 + i) << 3));
        check("full_count", count, 16);
        check("full_ovr", overrun, 0);
        step(1, 0, 0, 0, 11'h7f8);
        check("ovr_set", overrun, 1);
        check("ovr_count", count, 16);
        check("ovr_head", data_out, 11'h180);
        step(0, 0, 0, 1, '0);
        check("ovr_clear", overrun, 0);
        step(1, 1, 0, 0, 11'h5a8);
        check("pp_full_count", count, 16);
        check("pp_full_ovr", overrun, 0);
        check("pp_full_head", data_out, 11'h188);
        for (int i = 1; i < 16; i++) begin
            check("drain_seq", data_out, 11'((8'h30 + i) << 3));
            step(0, 1, 0, 0, '0);
        end
        check("drain_last", data_out, 11'h5a8);
        step(0, 1, 0, 0, '0);
        check("drain_empty", read_empty, 1);
        check("drain_ovr", overrun, 0);

        step(1, 1, 0, 0, 11'h310);
        check("pp_empty_count", count, 1);
        check("pp_empty_data", data_out, 11'h310);
        step(0, 1, 0, 0, '0);

        step(1, 0, 0, 0, 11'h100);
        check("err_clean", error_bit, 0);
        step(1, 0, 0, 0, 11'h10c);
        check("err_set", error_bit, 1);
        step(1, 0, 0, 0, 11'h110);
        step(0, 1, 0, 0, '0);
        check("err_still", error_bit, 1);
        check("err_head", data_out, 11'h10c);
        step(0, 1, 0, 0, '0);
        check("err_popped", error_bit, 0);
        step(1, 0, 0, 0, 11'h124);
        check("err_set2", error_bit, 1);
        step(0, 0, 1, 0, '0);
        check("flush_err", error_bit, 0);
        check("flush_count", count, 0);

        for (int k = 0; k < 40; k++) begin
            logic [10:0] d;
            d = 11'((k + 1) << 3);
            if (k == 20) begin
                step(0, 0, 1, 0, '0);
                model.delete();
                check("wrap_flush_count", count, 0);
                check("wrap_flush_empty", read_empty, 1);
            end
            if (model.size() < 2) begin
                step(1, 0, 0, 0, d);
            end else begin
                check("wrap_head", data_out, model[0]);
                step(1, 1, 0, 0, d);
                void'(model.pop_front());
            end
            model.push_back(d);
            check("wrap_count", count, model.size());
        end
        while (model.size() > 0) begin
            check("wrap_drain", data_out, model[0]);
            step(0, 1, 0, 0, '0);
            void'(model.pop_front());
        end
        check("wrap_end_empty", read_empty, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rfifo.md
UART_RFIFO -- requirements
Module: uart_rfifo

Interface
REQ-001 The block SHALL expose parameter fifo_width, default 11, entry width (bits [fifo_width-1:3] character, bits [2:0] error flags break/parity/framing); it SHALL be at least 4.
REQ-002 The block SHALL expose parameter fifo_depth, default 16, number of entries.
REQ-003 The block SHALL expose parameter fifo_pointer_w, default 4, read/write pointer width (log2 of fifo_depth).
REQ-004 The block SHALL expose parameter fifo_counter_w, default 5, count width.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data_in  input  fifo_width  entry to write.
REQ-008 push  input  1  single-cycle write request.
REQ-009 pop  input  1  single-cycle read request.
REQ-010 fifo_reset  input  1  synchronous FIFO flush.
REQ-011 reset_status  input  1  synchronous clear of overrun flag (LSR read).
REQ-012 data_out  output  fifo_width  entry at read pointer.
REQ-013 count  output  fifo_counter_w  number of stored entries, 0..fifo_depth.
REQ-014 overrun  output  1  sticky flag, push attempted while full.
REQ-015 read_empty  output  1  high when count is 0.
REQ-016 error_bit  output  1  some stored entry has a nonzero error field.

Function
REQ-017 Storage SHALL be fifo_depth entries of fifo_width bits, addressed by a write pointer and a read pointer that wrap from fifo_depth-1 to 0.
REQ-018 push alone with count<fifo_depth: write data_in at write pointer; write pointer +1; count +1; same edge.
REQ-019 pop alone with count>0: read pointer +1; count -1.
REQ-020 push and pop together with count>0 (including full): write and read both performed; both pointers +1; count unchanged; no overrun.
REQ-021 push and pop together with count=0: treated as push only; count becomes 1.
REQ-022 pop with count=0 SHALL be ignored; pointers and count unchanged.
REQ-023 push alone with count=fifo_depth SHALL be discarded (no write, no pointer change) and SHALL set overrun on that edge.
REQ-024 overrun SHALL stay set until a cycle with fifo_reset or reset_status high clears it; clear has priority over set in the same cycle.
REQ-025 fifo_reset high SHALL, on that edge, zero both pointers and count and clear all per-entry error flags; it has priority over push/pop in the same cycle; stored data need not be cleared.
REQ-026 data_out SHALL be combinational from the entry at read pointer (zero latency after a push into an empty FIFO); when empty it shows that location's stale contents.
REQ-027 read_empty SHALL be combinational: 1 iff count=0.
REQ-028 error_bit SHALL be combinational: OR of bits [2:0] over all entries currently stored (read pointer up to but excluding write pointer, wrap-aware); entries popped or flushed SHALL not contribute.
REQ-029 count SHALL never exceed fifo_depth nor underflow below 0.

Reset
REQ-030 On rst_n low, asynchronously: pointers=0, count=0, overrun=0, all error flags cleared, hence read_empty=1 and error_bit=0; storage contents may be left unreset except error field.
REQ-031 After rst_n deasserts, operation SHALL resume on the next rising edge with no extra idle cycles.

Verification
REQ-032 Reset, then push 0x41<<3 (0x208) -> next cycle count=1, read_empty=0, data_out=0x208, error_bit=0.
REQ-033 Push 16 distinct entries, then pop 16 -> count reaches 16, data_out sequence in push order, read_empty=1 at end, overrun=0.
REQ-034 With count=16, push alone -> overrun=1, count=16, head unchanged; pulse reset_status -> overrun=0.
REQ-035 Push entry with bits[2:0]=3'b100 (break) among clean entries -> error_bit=1 until that entry popped, then 0; also 0 after fifo_reset.
REQ-036 Push and pop same cycle at count=16 and at count=0 -> count stays 16 (no overrun), resp. becomes 1.
REQ-037 Wrap test: push/pop 40 entries keeping count between 1 and 3 -> FIFO order preserved across pointer wrap; fifo_reset mid-stream -> count=0, read_empty=1 next cycle.
